// File: rtl/ram_loader_if.sv
// ram_loader_if: host byte-stream handshake into the RAM loader.
//   s_valid  host -> loader   word valid
//   s_data   host -> loader   stream word
//   s_last   host -> loader   final word of frame
//   s_ready  loader -> host   loader accepts a word this cycle
// Modports: master = host side, slave = loader side.
interface ram_loader_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  s_ready;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/ram_loader.sv
// ram_loader: loads a host byte stream into the image or weight region of the
// accelerator RAM with sequential addresses, one write per accepted word.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   load_req         pulse: start a load of region load_sel (0 image, 1 weights)
//   accel_busy       blocks acceptance of load_req
//   stream           ram_loader_if.slave host stream (s_valid/s_data/s_last/s_ready)
//   ram_write_*      RAM write strobe/address/data, one cycle after each transfer
//   loading          load in progress
//   load_done        one-cycle pulse on a cleanly framed load
//   load_err         sticky framing error, cleared by the next accepted load_req
//   checksum         16-bit running byte sum of the current frame
// Build option: define LOADER_CHECKSUM_EN to build the checksum adder;
// otherwise checksum is tied to 0.
module ram_loader #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 11,
    parameter int unsigned N           = 5,
    parameter int unsigned MAX_WIDTH   = 32,
    parameter int unsigned IMG_BASE    = 0,
    parameter int unsigned WEIGHT_BASE = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_req,
    input  logic                  load_sel,
    input  logic                  accel_busy,
    ram_loader_if.slave           stream,
    output logic                  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  loading,
    output logic                  load_done,
    output logic                  load_err,
    output logic [15:0]           checksum
);
    localparam int unsigned WEIGHT_LEN = N * N;
    localparam int unsigned IMG_LEN    = MAX_WIDTH * MAX_WIDTH;
    localparam int unsigned CSUM_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic                  err_q, err_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  ready_q, done_q;
    logic [ADDR_WIDTH-1:0] base_c, last_idx_c;
    logic                  xfer_c;
`ifdef LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0]     csum_q, csum_d;
`endif

    // Region geometry follows the selection latched at load start.
    assign base_c     = sel_q ? ADDR_WIDTH'(WEIGHT_BASE) : ADDR_WIDTH'(IMG_BASE);
    assign last_idx_c = sel_q ? ADDR_WIDTH'(WEIGHT_LEN - 1) : ADDR_WIDTH'(IMG_LEN - 1);
    assign xfer_c     = stream.s_valid && (state_q == LOAD);

    // Next-state, counter, write-path and error logic.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        count_d   = count_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (load_req && !accel_busy) begin
                    state_d = LOAD;
                    sel_d   = load_sel;
                    count_d = '0;
                    err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LOAD: begin
                if (xfer_c) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_c + count_q;
                    wr_data_d = stream.s_data;
                    count_d   = count_q + ADDR_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
                    csum_d    = csum_q + CSUM_W'(stream.s_data);
`endif
                    // The final index ends the frame; missing s_last there is an error,
                    // s_last any earlier aborts the load.
                    if (count_q == last_idx_c) begin
                        state_d = DONE;
                        err_d   = !stream.s_last;
                    end else if (stream.s_last) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; status outputs are registered decodes of next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            count_q   <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            count_q   <= count_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ready_q   <= (state_d == LOAD);
            done_q    <= (state_d == DONE) && !err_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running byte sum of the current frame, wraps mod 2^16.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign stream.s_ready = ready_q;
    assign loading        = ready_q;
    assign load_done      = done_q;
    assign load_err       = err_q;
    assign ram_write_en   = wr_en_q;
    assign ram_write_addr = wr_addr_q;
    assign ram_write_data = wr_data_q;
endmodule

// File: tb/tb_ram_loader.sv
// Directed testbench for ram_loader: weight/image loads, busy blocking,
// framing errors, reset mid-load. Expected values are hand-derived constants.
module tb_ram_loader;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 11;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_req, load_sel, accel_busy;
    logic          ram_write_en;
    logic [AW-1:0] ram_write_addr;
    logic [DW-1:0] ram_write_data;
    logic          loading, load_done, load_err;
    logic [15:0]   checksum;

    ram_loader_if #(.DATA_WIDTH(DW)) sif ();

    ram_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_req       (load_req),
        .load_sel       (load_sel),
        .accel_busy     (accel_busy),
        .stream         (sif),
        .ram_write_en   (ram_write_en),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .loading        (loading),
        .load_done      (load_done),
        .load_err       (load_err),
        .checksum       (checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t wq[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  done_cnt = 0;
    int  b2b_cnt = 0;
    bit  prev_en = 1'b0;

    // Write/done monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_write_en === 1'b1) begin
            wq.push_back('{addr: ram_write_addr, data: ram_write_data});
            if (prev_en) b2b_cnt++;
        end
        prev_en = (ram_write_en === 1'b1);
        if (load_done === 1'b1) done_cnt++;
    end

    task automatic clear_mon();
        wq.delete();
        b2b_cnt = 0;
    endtask

    task automatic start_load(input bit sel);
        load_req = 1'b1;
        load_sel = sel;
        @(negedge clk);
        load_req = 1'b0;
        load_sel = 1'b0;
    endtask

    // Sends n words (data k+1), s_last on index last_idx; optional idle every other cycle.
    task automatic stream_words(input int n, input int last_idx, input bit gap, input int budget);
        int k = 0;
        int cyc = 0;
        bit hs;
        while (k < n && cyc < budget) begin
            if (gap && (cyc % 2 == 1)) begin
                sif.s_valid = 1'b0;
                sif.s_data  = 8'hAA;
                sif.s_last  = 1'b1;
            end else begin
                sif.s_valid = 1'b1;
                sif.s_data  = 8'(k + 1);
                sif.s_last  = (k == last_idx);
            end
            hs = sif.s_valid && (sif.s_ready === 1'b1);
            @(negedge clk);
            cyc++;
            if (hs) k++;
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        sif.s_data  = '0;
        vectors++;
        if (k != n) begin
            miscompares++;
            $display("FAIL stream_budget: accepted %0d words, required %0d", k, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (sif.s_ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready: got %b want 0", sif.s_ready); end
        vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL reset_loading: got %b want 0", loading); end
        vectors++; if (ram_write_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", ram_write_en); end
        vectors++; if (ram_write_addr !== 11'd0) begin miscompares++; $display("FAIL reset_wr_addr: got %0d want 0", ram_write_addr); end
        vectors++; if (ram_write_data !== 8'd0) begin miscompares++; $display("FAIL reset_wr_data: got %0d want 0", ram_write_data); end
        vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", load_done); end
        vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", load_err); end
        vectors++; if (checksum !== 16'd0) begin miscompares++; $display("FAIL reset_checksum: got %0d want 0", checksum); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_weight_load();
        int d0 = done_cnt;
        int bad = 0;
        clear_mon();
        start_load(1'b1);
        vectors++; if (loading !== 1'b1) begin miscompares++; $display("FAIL wt_loading: got %b want 1", loading); end
        stream_words(25, 24, 1'b0, 100);
        // Cycle after last transfer: final strobe and the DONE pulse coincide.
        vectors++; if (ram_write_en !== 1'b1) begin miscompares++; $display("FAIL wt_last_strobe: got %b want 1", ram_write_en); end
        vectors++; if (ram_write_addr !== 11'd1048) begin miscompares++; $display("FAIL wt_last_addr: got %0d want 1048", ram_write_addr); end
        vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL wt_done_pulse: got %b want 1", load_done); end
        vectors++; if (sif.s_ready !== 1'b0) begin miscompares++; $display("FAIL wt_ready_in_done: got %b want 0", sif.s_ready); end
        @(negedge clk); #1;
        vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL wt_done_width: got %b want 0", load_done); end
        vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL wt_idle: got %b want 0", loading); end
        vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL wt_err: got %b want 0", load_err); end
        vectors++; if (checksum !== (CSUM_ON ? 16'd325 : 16'd0)) begin miscompares++; $display("FAIL wt_checksum: got %0d want %0d", checksum, CSUM_ON ? 325 : 0); end
        vectors++; if (wq.size() != 25) begin miscompares++; $display("FAIL wt_write_count: got %0d want 25", wq.size()); end
        for (int i = 0; i < wq.size() && i < 25; i++)
            if (wq[i].addr !== 11'(1024 + i) || wq[i].data !== 8'(i + 1)) bad++;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL wt_write_seq: %0d wrong writes, want 0", bad); end
        vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL wt_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_image_toggle();
        int d0 = done_cnt;
        int bad = 0;
        clear_mon();
        start_load(1'b0);
        stream_words(1024, 1023, 1'b1, 2100);
        vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL img_done_pulse: got %b want 1", load_done); end
        @(negedge clk); #1;
        vectors++; if (wq.size() != 1024) begin miscompares++; $display("FAIL img_write_count: got %0d want 1024", wq.size()); end
        for (int i = 0; i < wq.size() && i < 1024; i++)
            if (wq[i].addr !== 11'(i) || wq[i].data !== 8'(i + 1)) bad++;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL img_write_seq: %0d wrong writes, want 0", bad); end
        vectors++; if (b2b_cnt != 0) begin miscompares++; $display("FAIL img_idle_strobes: got %0d adjacent strobes want 0", b2b_cnt); end
        vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL img_done_count: got %0d want 1", done_cnt - d0); end
        vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL img_err: got %b want 0", load_err); end
        // Bytes 1..255,0 repeated four times: 4*32640 mod 65536.
        vectors++; if (checksum !== (CSUM_ON ? 16'd65024 : 16'd0)) begin miscompares++; $display("FAIL img_checksum: got %0d want %0d", checksum, CSUM_ON ? 65024 : 0); end
    endtask

    task automatic test_busy();
        clear_mon();
        accel_busy = 1'b1;
        start_load(1'b0);
        sif.s_valid = 1'b1;
        sif.s_data  = 8'h55;
        repeat (3) @(negedge clk);
        vectors++; if (sif.s_ready !== 1'b0) begin miscompares++; $display("FAIL busy_ready: got %b want 0", sif.s_ready); end
        vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL busy_loading: got %b want 0", loading); end
        vectors++; if (wq.size() != 0) begin miscompares++; $display("FAIL busy_writes: got %0d want 0", wq.size()); end
        sif.s_valid = 1'b0;
        accel_busy = 1'b0;
        @(negedge clk);
        start_load(1'b1);
        vectors++; if (sif.s_ready !== 1'b1) begin miscompares++; $display("FAIL busy_release_ready: got %b want 1", sif.s_ready); end
        stream_words(25, 24, 1'b0, 100);
        @(negedge clk); #1;
        vectors++; if (wq.size() != 25 || wq[0].addr !== 11'd1024) begin miscompares++; $display("FAIL busy_release_load: got %0d writes want 25 from addr 1024", wq.size()); end
    endtask

    task automatic test_early_last();
        int d0 = done_cnt;
        int bad = 0;
        clear_mon();
        start_load(1'b1);
        stream_words(10, 9, 1'b0, 100);
        // Aborted straight to IDLE; the last accepted word is still written.
        vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL early_idle: got %b want 0", loading); end
        vectors++; if (load_err !== 1'b1) begin miscompares++; $display("FAIL early_err: got %b want 1", load_err); end
        vectors++; if (ram_write_en !== 1'b1 || ram_write_addr !== 11'd1033) begin miscompares++; $display("FAIL early_last_write: got en %b addr %0d want en 1 addr 1033", ram_write_en, ram_write_addr); end
        repeat (2) @(negedge clk); #1;
        vectors++; if (wq.size() != 10) begin miscompares++; $display("FAIL early_write_count: got %0d want 10", wq.size()); end
        for (int i = 0; i < wq.size() && i < 10; i++)
            if (wq[i].addr !== 11'(1024 + i) || wq[i].data !== 8'(i + 1)) bad++;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL early_write_seq: %0d wrong writes, want 0", bad); end
        vectors++; if (done_cnt != d0) begin miscompares++; $display("FAIL early_no_done: got %0d pulses want 0", done_cnt - d0); end
        vectors++; if (load_err !== 1'b1) begin miscompares++; $display("FAIL early_err_sticky: got %b want 1", load_err); end
        vectors++; if (checksum !== (CSUM_ON ? 16'd55 : 16'd0)) begin miscompares++; $display("FAIL early_checksum: got %0d want %0d", checksum, CSUM_ON ? 55 : 0); end
        start_load(1'b1);
        vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL early_err_clear: got %b want 0", load_err); end
        stream_words(25, 24, 1'b0, 100);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        clear_mon();
        start_load(1'b0);
        stream_words(500, -1, 1'b0, 600);
        sif.s_valid = 1'b1;
        sif.s_data  = 8'hF5;
        rst_n = 1'b0;
        @(negedge clk);
        sif.s_valid = 1'b0;
        vectors++; if (loading !== 1'b0 || sif.s_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle: got loading %b ready %b want 0 0", loading, sif.s_ready); end
        vectors++; if (ram_write_en !== 1'b0 || ram_write_addr !== 11'd0 || ram_write_data !== 8'd0) begin miscompares++; $display("FAIL rstmid_write_bus: got en %b addr %0d data %0d want 0 0 0", ram_write_en, ram_write_addr, ram_write_data); end
        vectors++; if (load_done !== 1'b0 || load_err !== 1'b0 || checksum !== 16'd0) begin miscompares++; $display("FAIL rstmid_status: got done %b err %b csum %0d want 0 0 0", load_done, load_err, checksum); end
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        start_load(1'b0);
        stream_words(3, -1, 1'b0, 20);
        @(negedge clk); #1;
        vectors++; if (wq.size() != 3 || wq[0].addr !== 11'd0 || wq[2].addr !== 11'd2) begin miscompares++; $display("FAIL rstmid_fresh_addr: got %0d writes first addr %0d want 3 writes from 0", wq.size(), wq.size() > 0 ? wq[0].addr : 11'h7ff); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_missing_last();
        int d0 = done_cnt;
        clear_mon();
        start_load(1'b1);
        stream_words(25, -1, 1'b0, 100);
        vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL nolast_done: got %b want 0", load_done); end
        vectors++; if (load_err !== 1'b1) begin miscompares++; $display("FAIL nolast_err: got %b want 1", load_err); end
        vectors++; if (ram_write_en !== 1'b1 || ram_write_addr !== 11'd1048) begin miscompares++; $display("FAIL nolast_last_write: got en %b addr %0d want en 1 addr 1048", ram_write_en, ram_write_addr); end
        repeat (2) @(negedge clk); #1;
        vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL nolast_idle: got %b want 0", loading); end
        vectors++; if (wq.size() != 25) begin miscompares++; $display("FAIL nolast_write_count: got %0d want 25", wq.size()); end
        vectors++; if (done_cnt != d0) begin miscompares++; $display("FAIL nolast_no_done: got %0d pulses want 0", done_cnt - d0); end
        vectors++; if (checksum !== (CSUM_ON ? 16'd325 : 16'd0)) begin miscompares++; $display("FAIL nolast_checksum: got %0d want %0d", checksum, CSUM_ON ? 325 : 0); end
    endtask

    initial begin
        rst_n       = 1'b0;
        load_req    = 1'b0;
        load_sel    = 1'b0;
        accel_busy  = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;
        @(negedge clk);
        test_reset();
        test_weight_load();
        test_image_toggle();
        test_busy();
        test_early_last();
        test_reset_mid_load();
        test_missing_last();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
